// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the multicore data-memory controllers.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned NUM_CORES = 4;

    typedef logic [1:0] core_idx_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: grants the first request at or after ptr.
module rr_arbiter4
    import mem_ctrl_pkg::*;
(
    input  logic [3:0] req,
    input  core_idx_t  ptr,
    input  logic       en,
    output logic [3:0] gnt,
    output core_idx_t  gnt_idx,
    output logic       valid
);

    core_idx_t idx;

    always_comb begin
        idx     = ptr;
        gnt_idx = ptr;
        valid   = 1'b0;
        // Scan from the farthest offset down so the nearest request to ptr wins.
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + core_idx_t'(k);
            if (en && req[idx]) begin
                gnt_idx = idx;
                valid   = 1'b1;
            end
        end
        gnt = valid ? (4'b0001 << gnt_idx) : 4'b0000;
    end

endmodule

// File: rtl/data_store_controller.sv
// Buffers one store per core and serialises them onto the single data-memory write port,
// round-robin, yielding the port while the load controller holds it.
module data_store_controller
    import mem_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_CORES-1:0] MW,
    input  logic [ADDR_W-1:0]    MADDR1,
    input  logic [ADDR_W-1:0]    MADDR2,
    input  logic [ADDR_W-1:0]    MADDR3,
    input  logic [ADDR_W-1:0]    MADDR4,
    input  logic [DATA_W-1:0]    MDIN1,
    input  logic [DATA_W-1:0]    MDIN2,
    input  logic [DATA_W-1:0]    MDIN3,
    input  logic [DATA_W-1:0]    MDIN4,
    input  logic                 HOLD,
    output logic [NUM_CORES-1:0] STALL,
    output logic [NUM_CORES-1:0] WACK,
    output logic                 MEMWRITE,
    output logic [ADDR_W-1:0]    MEMADDR,
    output logic [DATA_W-1:0]    MEMDATA
);

    logic [ADDR_W-1:0]    maddr [NUM_CORES];
    logic [DATA_W-1:0]    mdin  [NUM_CORES];

    logic [NUM_CORES-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0]    addr_q [NUM_CORES];
    logic [ADDR_W-1:0]    addr_d [NUM_CORES];
    logic [DATA_W-1:0]    data_q [NUM_CORES];
    logic [DATA_W-1:0]    data_d [NUM_CORES];
    core_idx_t            ptr_q, ptr_d;
    logic                 memwrite_q, memwrite_d;
    logic [ADDR_W-1:0]    memaddr_q, memaddr_d;
    logic [DATA_W-1:0]    memdata_q, memdata_d;
    logic [NUM_CORES-1:0] wack_q, wack_d;

    logic [3:0]           gnt;
    core_idx_t            gnt_idx;
    logic                 gnt_valid;

    assign maddr[0] = MADDR1;
    assign maddr[1] = MADDR2;
    assign maddr[2] = MADDR3;
    assign maddr[3] = MADDR4;
    assign mdin[0]  = MDIN1;
    assign mdin[1]  = MDIN2;
    assign mdin[2]  = MDIN3;
    assign mdin[3]  = MDIN4;

    rr_arbiter4 u_arb (
        .req     (pend_q),
        .ptr     (ptr_q),
        .en      (!HOLD),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .valid   (gnt_valid)
    );

    always_comb begin
        pend_d     = pend_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ptr_d      = ptr_q;
        memwrite_d = gnt_valid;
        wack_d     = gnt;
        memaddr_d  = memaddr_q;
        memdata_d  = memdata_q;
        // Capture only into empty slots; a granted slot is never also captured this edge.
        for (int i = 0; i < NUM_CORES; i++) begin
            if (MW[i] && !pend_q[i]) begin
                pend_d[i] = 1'b1;
                addr_d[i] = maddr[i];
                data_d[i] = mdin[i];
            end
        end
        if (gnt_valid) begin
            pend_d[gnt_idx] = 1'b0;
            memaddr_d       = addr_q[gnt_idx];
            memdata_d       = data_q[gnt_idx];
            ptr_d           = gnt_idx + core_idx_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_q     <= '0;
            addr_q     <= '{default: '0};
            data_q     <= '{default: '0};
            ptr_q      <= '0;
            memwrite_q <= 1'b0;
            memaddr_q  <= '0;
            memdata_q  <= '0;
            wack_q     <= '0;
        end else begin
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ptr_q      <= ptr_d;
            memwrite_q <= memwrite_d;
            memaddr_q  <= memaddr_d;
            memdata_q  <= memdata_d;
            wack_q     <= wack_d;
        end
    end

    assign STALL    = pend_q;
    assign WACK     = wack_q;
    assign MEMWRITE = memwrite_q;
    assign MEMADDR  = memaddr_q;
    assign MEMDATA  = memdata_q;

endmodule

// File: doc/data_store_controller.md
Name: data_store_controller

Overview:
- Write-side counterpart of the data-load controller in the multicore memory subsystem.
- Accepts store requests from 4 cores, each with a 16-bit address and 16-bit data, and buffers one pending store per core.
- Serialises the buffered stores onto the single-port data memory write interface using round-robin arbitration, and returns a per-core acknowledge.
- Yields the memory port whenever the load controller holds it (HOLD).

Parameters:
ADDR_W, 16, address width per core and on the memory side
DATA_W, 16, store data width per core and on the memory side
NUM_CORES, 4, number of requesting cores (fixed at 4; port list is unrolled)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  synchronous active-low reset
MW  input  4  store request, bit i = core i+1
MADDR1..MADDR4  input  ADDR_W each  store address per core
MDIN1..MDIN4  input  DATA_W each  store data per core
HOLD  input  1  memory port in use by load controller; no write issued while high
STALL  output  4  bit i high = core i slot occupied; new request ignored
WACK  output  4  one-cycle pulse, bit i = core i store written this cycle
MEMWRITE  output  1  data memory write enable
MEMADDR  output  ADDR_W  data memory address
MEMDATA  output  DATA_W  data memory write data

Behaviour:
- All outputs are registered. Reset values: STALL=0, WACK=0, MEMWRITE=0, MEMADDR=0, MEMDATA=0, round-robin pointer=0, slots empty.
- Capture:
  - At a rising edge where MW[i]=1 and PEND[i]=0, latch MADDRi/MDINi into slot i and set PEND[i].
  - STALL equals PEND.
  - MW[i] while PEND[i]=1 is ignored. The core must hold the request until STALL[i] is low and the capture edge has passed.
- Arbitration: each cycle with HOLD=0 and PEND≠0, grant g = first set PEND bit at or after ptr, scanning i = ptr, ptr+1, … modulo 4 (wraps 3→0).
- Issue on the edge after the grant:
  - MEMWRITE<=1, MEMADDR<=slot g addr, MEMDATA<=slot g data, WACK<=(1<<g).
  - PEND[g] is cleared and ptr<=(g+1) mod 4.
- With no grant (HOLD=1 or PEND=0):
  - MEMWRITE<=0 and WACK<=0.
  - MEMADDR/MEMDATA keep their previous values.
  - ptr is unchanged.
- Latency, uncontended:
  - MW sampled at edge k.
  - PEND set after edge k.
  - MEMWRITE/WACK high during the cycle after edge k+1.
  - STALL falls together with WACK.
- Throughput: one store per cycle total; each core can have at most one store every 2 cycles.
- Simultaneous events:
  - Clearing PEND[g] and a new MW[g] on the same edge: the request is not captured because PEND was set at sampling. It is accepted on the next edge.
  - HOLD rising while PEND is set: pending stores wait with no loss. Order after HOLD falls follows ptr.
- Fairness: with all 4 slots continuously pending, grants go 0,1,2,3,0… Maximum wait is 4 issue cycles plus HOLD time.
- Reset mid-operation: pending slots are discarded with no WACK. MEMWRITE is low in the cycle after the reset edge.
- No address compare across cores: same-address stores land in grant order.

Decomposition:
- Shared package mem_ctrl_pkg: ADDR_W, DATA_W and NUM_CORES constants, plus a core-index type (2 bits).
- Sub-module rr_arbiter4:
  - Inputs: req[3:0], ptr[1:0], en.
  - Outputs: gnt onehot[3:0], gnt_idx[1:0], valid.
  - Purely combinational.
  - ptr register stays in the top level.

Test Plan:
- Reset and single store: rstn=0 for 2 cycles → all outputs 0. Then MW=0001, MADDR1=0x0010, MDIN1=0xBEEF for 1 cycle → STALL=0001 next cycle; MEMWRITE=1, MEMADDR=0x0010, MEMDATA=0xBEEF, WACK=0001 one cycle later; then STALL=0000.
- All-core contention: MW=1111 with addrs 0x0100..0x0103 and data 0xA000..0xA003 → four consecutive MEMWRITE cycles in order core1..4, WACK 0001,0010,0100,1000, STALL bits clear one per cycle.
- Pointer wrap: after the core-4 grant (ptr=0), raise MW=1001 → core1 granted first, then core4. Repeat after a core-1-only grant (ptr=1) → core4 before core1.
- HOLD: slot 2 pending and HOLD=1 for 5 cycles → MEMWRITE=0 and STALL[1]=1 throughout. HOLD falls → write issues the next cycle with the correct addr/data.
- Request while stalled: MW[0] held high for 6 cycles with data changing each cycle → each captured store equals MDIN1 at the capture edges only (every 2nd cycle). No store is dropped or duplicated beyond those edges.
- Mid-operation reset: 3 slots pending, rstn=0 for one edge → STALL=0, WACK=0, MEMWRITE=0, and no stale write after rstn returns high.
